div_unit: RTL and testbench

- Iterative 32-bit radix-2 restoring divider serving the execute stage for DIV/DIVU.
- The execute stage holds start_i and requests a pipeline stall (stall[3]) until ready_o rises.
- It then forwards result_o as {HI=remainder, LO=quotient} into the EX/MEM register as hi/lo write data.
- annul_i aborts an in-flight divide when the pipeline is flushed (exception).

---
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Operands are captured on the edge that accepts start_i; one quotient bit is
// produced per clock. The result is presented as {remainder, quotient} and held
// with ready_o while the execute stage keeps start_i asserted.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   signed_div_i  1 = signed DIV, 0 = unsigned DIVU (sampled with start_i)
//   opdata1_i     dividend (sampled with start_i)
//   opdata2_i     divisor (sampled with start_i)
//   start_i       divide request, held until ready_o is seen
//   annul_i       abort the current operation (pipeline flush)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//
// State      | meaning
// ST_FREE    | idle, waiting for start_i
// ST_BYZERO  | divisor was zero, produce a zero result
// ST_ON      | iterating, one quotient bit per edge
// ST_END     | result final, presented while start_i stays high
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o
);

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_BYZERO = 2'd1,
      ST_ON     = 2'd2,
      ST_END    = 2'd3
   } state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_dvd;      // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0]     r_dvs;
   logic [WIDTH-1:0]     r_rem;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic [2*WIDTH-1:0]   r_result;
   logic                 r_ready;

   logic [WIDTH-1:0]     w_op1_abs;
   logic [WIDTH-1:0]     w_op2_abs;
   logic [WIDTH:0]       w_trial;
   logic                 w_qbit;
   logic [WIDTH-1:0]     w_rem_nx;
   logic [WIDTH-1:0]     w_quo_nx;
   logic                 w_last;

   assign w_op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign w_op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

   // One extra bit so a shifted remainder with its top bit set still compares correctly.
   assign w_trial  = {r_rem, r_dvd[WIDTH-1]} - {1'b0, r_dvs};
   assign w_qbit   = ~w_trial[WIDTH];
   assign w_rem_nx = w_qbit ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
   assign w_quo_nx = {r_dvd[WIDTH-2:0], w_qbit};
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_FREE;
         r_cnt    <= '0;
         r_dvd    <= '0;
         r_dvs    <= '0;
         r_rem    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
         r_ready  <= 1'b0;
      end else begin
         case (r_state)
            ST_FREE: begin
               r_ready  <= 1'b0;
               r_result <= '0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     r_state <= ST_BYZERO;
                  end else begin
                     r_dvd   <= w_op1_abs;
                     r_dvs   <= w_op2_abs;
                     r_rem   <= '0;
                     r_cnt   <= '0;
                     r_neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                     r_neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                     r_state <= ST_ON;
                  end
               end
            end
            ST_BYZERO: begin
               r_dvd   <= '0;
               r_rem   <= '0;
               r_state <= annul_i ? ST_FREE : ST_END;
            end
            ST_ON: begin
               if (annul_i) begin
                  r_state <= ST_FREE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     // Sign fix-up folded into the final iteration.
                     r_dvd   <= r_neg_q ? -w_quo_nx : w_quo_nx;
                     r_rem   <= r_neg_r ? -w_rem_nx : w_rem_nx;
                     r_state <= ST_END;
                  end else begin
                     r_dvd <= w_quo_nx;
                     r_rem <= w_rem_nx;
                  end
               end
            end
            ST_END: begin
               if (start_i && !annul_i) begin
                  r_ready  <= 1'b1;
                  r_result <= {r_rem, r_dvd};
               end else begin
                  r_ready  <= 1'b0;
                  r_result <= '0;
                  r_state  <= ST_FREE;
               end
            end
            default: r_state <= ST_FREE;
         endcase
      end
   end

   assign result_o = r_result;
   assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, arithmetic, divide-by-zero, annul,
// reset mid-operation and back-to-back operations.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_checks = 0;
   int n_errors = 0;

   div_unit #(.WIDTH(32), .CNT_W(6)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present operands at a negedge; returns 1 ns after E0.
   task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Number of edges after E0 until ready_o is seen; 0 if never within budget.
   task automatic wait_ready(output int n);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (ready_o) begin
            n = i;
            break;
         end
      end
   endtask

   // Drop start_i at the next negedge and check the output clears one edge later.
   task automatic drop_start(input string tag);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_rdy_clr"}, {63'd0, ready_o}, 64'd0);
      check({tag, "_res_clr"}, result_o, 64'd0);
   endtask

   task automatic full_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] exp);
      int n;
      start_op(sgn, a, b);
      check({tag, "_e0_rdy"}, {63'd0, ready_o}, 64'd0);
      wait_ready(n);
      check({tag, "_lat"}, 64'(n), 64'(lat));
      check({tag, "_res"}, result_o, exp);
      @(posedge clk);
      #1;
      check({tag, "_hold"}, {63'd0, ready_o}, 64'd1);
      check({tag, "_hold_res"}, result_o, exp);
      drop_start(tag);
   endtask

   initial begin
      int  n;
      logic seen;
      rst          = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      #12;
      check("rst_rdy", {63'd0, ready_o}, 64'd0);
      check("rst_res", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      full_op("divu_ff", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 33, {32'h0000_000F, 32'h0FFF_FFFF});
      full_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      full_op("div_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 33, {32'h0000_0001, 32'hFFFF_FFFD});
      full_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0000_0000, 32'h8000_0000});
      full_op("div_zero", 1'b1, 32'h1234_5678, 32'h0000_0000, 2, 64'd0);
      full_op("divu_big", 1'b0, 32'h8000_0000, 32'h0000_0003, 33, {32'h0000_0002, 32'h2AAA_AAAA});

      // Reset in the middle of an iteration.
      start_op(1'b1, 32'd1000, 32'd7);
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_rdy", {63'd0, ready_o}, 64'd0);
      check("midrst_res", result_o, 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b1;
      full_op("post_rst", 1'b0, 32'd1000, 32'd7, 33, {32'd6, 32'd142});

      // Annul at iteration 5: no result may ever appear.
      start_op(1'b1, 32'd100, 32'd3);
      repeat (5) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      check("annul_rdy", {63'd0, ready_o}, 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ready_o) seen = 1'b1;
      end
      check("annul_never", {63'd0, seen}, 64'd0);
      full_op("after_annul", 1'b0, 32'd100, 32'd3, 33, {32'd1, 32'd33});

      // start_i and annul_i both high in FREE: annul wins.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd50;
      opdata2_i    = 32'd5;
      start_i      = 1'b1;
      annul_i      = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ready_o) seen = 1'b1;
      end
      check("annul_free", {63'd0, seen}, 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      annul_i = 1'b0;

      // Back-to-back with start_i low for exactly one cycle.
      start_op(1'b0, 32'd77, 32'd10);
      wait_ready(n);
      check("b2b1_lat", 64'(n), 64'd33);
      check("b2b1_res", result_o, {32'd7, 32'd7});
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check("b2b_gap_rdy", {63'd0, ready_o}, 64'd0);
      start_op(1'b0, 32'd1000, 32'd9);
      check("b2b2_e0_rdy", {63'd0, ready_o}, 64'd0);
      check("b2b2_e0_res", result_o, 64'd0);
      wait_ready(n);
      check("b2b2_lat", 64'(n), 64'd33);
      check("b2b2_res", result_o, {32'd1, 32'd111});
      drop_start("b2b2");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
